// File: rtl/branch_predictor_if.sv
// Fetch/EX connection bundle for branch_predictor: IF prediction lookup, EX branch
// resolution, comparator control and redirect.
interface branch_predictor_if;
  logic [31:0] pc_if_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i;
  logic        ex_is_branch_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        BrEq_i;
  logic        BrLt_i;
  logic        BrUn_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;

  modport slave (
    input  pc_if_i, ex_valid_i, ex_is_branch_i, ex_funct3_i, ex_pc_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i, BrEq_i, BrLt_i,
    output pred_taken_o, pred_target_o, BrUn_o, mispredict_o, redirect_pc_o
  );

  modport master (
    output pc_if_i, ex_valid_i, ex_is_branch_i, ex_funct3_i, ex_pc_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i, BrEq_i, BrLt_i,
    input  pred_taken_o, pred_target_o, BrUn_o, mispredict_o, redirect_pc_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; resolves branches in EX and trains.
// Optional macro BP_STATS_EN adds branch / mispredict event counters.
module branch_predictor #(
  parameter int IDX_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  branch_predictor_if.slave  bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0]        stat_br_o,
  output logic [31:0]        stat_misp_o
`endif
);

  localparam int TAG_W = 32 - IDX_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [1:0]       ctr_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [31:0]      tgt_q [DEPTH];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;

  logic             br_ok, taken, act, misp;
  logic [31:0]      redirect;
  logic             entry_we, alloc_we, tgt_we;
  logic [1:0]       ctr_d;

  assign if_idx = bus.pc_if_i[IDX_W+1:2];
  assign if_tag = bus.pc_if_i[31:IDX_W+2];
  assign ex_idx = bus.ex_pc_i[IDX_W+1:2];
  assign ex_tag = bus.ex_pc_i[31:IDX_W+2];

  // Lookup reads the registered table only, so a same-cycle EX write is not visible.
  assign if_hit            = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bus.pred_taken_o  = if_hit && ctr_q[if_idx][1];
  assign bus.pred_target_o = if_hit ? tgt_q[if_idx] : 32'd0;

  assign bus.BrUn_o = bus.ex_funct3_i[1];

  always_comb begin
    br_ok = 1'b1;
    taken = 1'b0;
    case (bus.ex_funct3_i)
      3'b000:          taken = bus.BrEq_i;
      3'b001:          taken = ~bus.BrEq_i;
      3'b100, 3'b110:  taken = bus.BrLt_i;
      3'b101, 3'b111:  taken = ~bus.BrLt_i;
      default:         br_ok = 1'b0;
    endcase
  end

  assign act      = bus.ex_valid_i && bus.ex_is_branch_i && br_ok;
  assign misp     = act && ((taken != bus.ex_pred_taken_i) ||
                            (taken && (bus.ex_pred_target_i != bus.ex_target_i)));
  assign redirect = taken ? bus.ex_target_i : (bus.ex_pc_i + 32'd4);

  assign bus.mispredict_o  = misp;
  assign bus.redirect_pc_o = act ? redirect : 32'd0;

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // A hit trains the counter; a taken miss replaces the whole entry; a not-taken miss is dropped.
  always_comb begin
    entry_we = act && (ex_hit || taken);
    alloc_we = act && !ex_hit && taken;
    tgt_we   = act && taken;
    ctr_d    = 2'b10;
    if (ex_hit) begin
      ctr_d = ctr_q[ex_idx];
      if (taken && (ctr_q[ex_idx] != 2'b11))
        ctr_d = ctr_q[ex_idx] + 2'd1;
      else if (!taken && (ctr_q[ex_idx] != 2'b00))
        ctr_d = ctr_q[ex_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
    end else if (entry_we) begin
      valid_q[ex_idx] <= 1'b1;
      ctr_q[ex_idx]   <= ctr_d;
    end
  end

  // Tags and targets need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    if (alloc_we) tag_q[ex_idx] <= ex_tag;
    if (tgt_we)   tgt_q[ex_idx] <= bus.ex_target_i;
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_misp_q, stat_misp_d;

  assign stat_br_d   = stat_br_q + {31'd0, act};
  assign stat_misp_d = stat_misp_q + {31'd0, misp};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_br_q   <= '0;
      stat_misp_q <= '0;
    end else begin
      stat_br_q   <= stat_br_d;
      stat_misp_q <= stat_misp_d;
    end
  end

  assign stat_br_o   = stat_br_q;
  assign stat_misp_o = stat_misp_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: hand-computed expectations checked by immediate assertions.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor_if bus ();

`ifdef BP_STATS_EN
  logic [31:0] stat_br, stat_misp;
  branch_predictor #(.IDX_W(6)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .stat_br_o(stat_br), .stat_misp_o(stat_misp)
  );
`else
  branch_predictor #(.IDX_W(6)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic v, input logic br, input logic [2:0] f3,
                    input logic [31:0] pc, input logic [31:0] tgt,
                    input logic pt, input logic [31:0] ptg,
                    input logic eq, input logic lt);
    bus.ex_valid_i       = v;
    bus.ex_is_branch_i   = br;
    bus.ex_funct3_i      = f3;
    bus.ex_pc_i          = pc;
    bus.ex_target_i      = tgt;
    bus.ex_pred_taken_i  = pt;
    bus.ex_pred_target_i = ptg;
    bus.BrEq_i           = eq;
    bus.BrLt_i           = lt;
  endtask

  task automatic idle();
    ex(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.pc_if_i = 32'h100;
    #2;
    chk("pred_in_reset", {31'd0, bus.pred_taken_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("rst_pred_taken", {31'd0, bus.pred_taken_o}, 32'd0);
    chk("rst_pred_target", bus.pred_target_o, 32'd0);
    chk("rst_misp", {31'd0, bus.mispredict_o}, 32'd0);
    chk("rst_redirect", bus.redirect_pc_o, 32'd0);
`ifdef BP_STATS_EN
    chk("rst_stat_br", stat_br, 32'd0);
    chk("rst_stat_misp", stat_misp, 32'd0);
`endif

    // BEQ taken, predicted not taken: allocate with ctr=10
    @(negedge clk) ex(1, 1, 3'b000, 32'h100, 32'h140, 0, 32'h0, 1, 0);
    #1;
    chk("beq1_misp", {31'd0, bus.mispredict_o}, 32'd1);
    chk("beq1_redirect", bus.redirect_pc_o, 32'h140);
    chk("beq1_brun", {31'd0, bus.BrUn_o}, 32'd0);
    chk("beq1_no_bypass", {31'd0, bus.pred_taken_o}, 32'd0);
    @(negedge clk) idle();
    #1;
    chk("alloc_pred_taken", {31'd0, bus.pred_taken_o}, 32'd1);
    chk("alloc_pred_target", bus.pred_target_o, 32'h140);

    // two more taken -> ctr saturates at 11
    @(negedge clk) ex(1, 1, 3'b000, 32'h100, 32'h140, 1, 32'h140, 1, 0);
    #1;
    chk("beq2_misp", {31'd0, bus.mispredict_o}, 32'd0);
    chk("beq2_redirect", bus.redirect_pc_o, 32'h140);
    @(negedge clk) ex(1, 1, 3'b000, 32'h100, 32'h140, 1, 32'h140, 1, 0);
    #1;
    chk("beq3_misp", {31'd0, bus.mispredict_o}, 32'd0);

    // not taken: 11 -> 10 still predicts taken
    @(negedge clk) ex(1, 1, 3'b000, 32'h100, 32'h140, 1, 32'h140, 0, 0);
    #1;
    chk("nt1_misp", {31'd0, bus.mispredict_o}, 32'd1);
    chk("nt1_redirect", bus.redirect_pc_o, 32'h104);
    @(negedge clk) idle();
    #1;
    chk("ctr10_pred", {31'd0, bus.pred_taken_o}, 32'd1);
    chk("ctr10_target", bus.pred_target_o, 32'h140);
    // not taken again: 10 -> 01, still a hit but predicts not taken
    @(negedge clk) ex(1, 1, 3'b000, 32'h100, 32'h140, 1, 32'h140, 0, 0);
    #1;
    chk("nt2_misp", {31'd0, bus.mispredict_o}, 32'd1);
    @(negedge clk) idle();
    #1;
    chk("ctr01_pred", {31'd0, bus.pred_taken_o}, 32'd0);
    chk("ctr01_target", bus.pred_target_o, 32'h140);

    // comparator unsigned select
    bus.ex_funct3_i = 3'b110;
    #1;
    chk("bltu_brun", {31'd0, bus.BrUn_o}, 32'd1);
    bus.ex_funct3_i = 3'b101;
    #1;
    chk("bge_brun", {31'd0, bus.BrUn_o}, 32'd0);

    // BGE taken, predicted taken with correct target
    @(negedge clk) ex(1, 1, 3'b101, 32'h180, 32'h1c0, 1, 32'h1c0, 0, 0);
    #1;
    chk("bge_ok_misp", {31'd0, bus.mispredict_o}, 32'd0);
    chk("bge_ok_redirect", bus.redirect_pc_o, 32'h1c0);
    // taken with wrong predicted target
    @(negedge clk) ex(1, 1, 3'b101, 32'h180, 32'h1c0, 1, 32'h1d0, 0, 0);
    #1;
    chk("bge_tgt_misp", {31'd0, bus.mispredict_o}, 32'd1);
    // BGE not taken, predicted not taken
    @(negedge clk) ex(1, 1, 3'b101, 32'h180, 32'h1c0, 0, 32'h0, 0, 1);
    #1;
    chk("bge_nt_misp", {31'd0, bus.mispredict_o}, 32'd0);
    chk("bge_nt_redirect", bus.redirect_pc_o, 32'h184);
    // BNE taken
    @(negedge clk) ex(1, 1, 3'b001, 32'h108, 32'h400, 0, 32'h0, 0, 0);
    #1;
    chk("bne_misp", {31'd0, bus.mispredict_o}, 32'd1);
    chk("bne_redirect", bus.redirect_pc_o, 32'h400);
    // BLT taken, predicted correctly
    @(negedge clk) ex(1, 1, 3'b100, 32'h10c, 32'h80, 1, 32'h80, 0, 1);
    #1;
    chk("blt_misp", {31'd0, bus.mispredict_o}, 32'd0);
    chk("blt_redirect", bus.redirect_pc_o, 32'h80);
    // BLTU not taken, predicted taken
    @(negedge clk) ex(1, 1, 3'b110, 32'h110, 32'h90, 1, 32'h90, 0, 0);
    #1;
    chk("bltu_misp", {31'd0, bus.mispredict_o}, 32'd1);
    chk("bltu_redirect", bus.redirect_pc_o, 32'h114);
    // BGEU taken, predicted not taken
    @(negedge clk) ex(1, 1, 3'b111, 32'h114, 32'h20, 0, 32'h0, 0, 0);
    #1;
    chk("bgeu_misp", {31'd0, bus.mispredict_o}, 32'd1);
    chk("bgeu_redirect", bus.redirect_pc_o, 32'h20);

    // aliasing: 0x200 shares index 0 with 0x100 and replaces it
    @(negedge clk) ex(1, 1, 3'b000, 32'h100, 32'h140, 0, 32'h0, 1, 0);
    @(negedge clk) ex(1, 1, 3'b000, 32'h200, 32'h280, 0, 32'h0, 1, 0);
    #1;
    chk("alias_misp", {31'd0, bus.mispredict_o}, 32'd1);
    @(negedge clk) idle();
    bus.pc_if_i = 32'h100;
    #1;
    chk("alias_old_pred", {31'd0, bus.pred_taken_o}, 32'd0);
    chk("alias_old_target", bus.pred_target_o, 32'd0);
    bus.pc_if_i = 32'h200;
    #1;
    chk("alias_new_pred", {31'd0, bus.pred_taken_o}, 32'd1);
    chk("alias_new_target", bus.pred_target_o, 32'h280);

    // funct3=010 is not a branch: no flush, no redirect, no table write
    @(negedge clk) ex(1, 1, 3'b010, 32'h104, 32'h500, 1, 32'h500, 1, 1);
    #1;
    chk("f010_misp", {31'd0, bus.mispredict_o}, 32'd0);
    chk("f010_redirect", bus.redirect_pc_o, 32'd0);
    @(negedge clk) idle();
    bus.pc_if_i = 32'h104;
    #1;
    chk("f010_no_write", {31'd0, bus.pred_taken_o}, 32'd0);
    // valid but not a branch
    @(negedge clk) ex(1, 0, 3'b000, 32'h104, 32'h500, 1, 32'h500, 1, 0);
    #1;
    chk("nobr_misp", {31'd0, bus.mispredict_o}, 32'd0);
    chk("nobr_redirect", bus.redirect_pc_o, 32'd0);
    // fall-through wraps modulo 2^32
    @(negedge clk) ex(1, 1, 3'b000, 32'hffff_fffc, 32'h10, 0, 32'h0, 0, 0);
    #1;
    chk("wrap_redirect", bus.redirect_pc_o, 32'd0);
    chk("wrap_misp", {31'd0, bus.mispredict_o}, 32'd0);

    // async reset mid-operation clears the table immediately
    @(negedge clk) ex(1, 1, 3'b000, 32'h1f0, 32'h600, 0, 32'h0, 1, 0);
    bus.pc_if_i = 32'h180;
    #1;
    chk("pre_rst_pred", {31'd0, bus.pred_taken_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pred", {31'd0, bus.pred_taken_o}, 32'd0);
    chk("mid_rst_target", bus.pred_target_o, 32'd0);
    @(negedge clk) idle();
    @(negedge clk) rst_n = 1'b1;
    bus.pc_if_i = 32'h1f0;
    #1;
    chk("rst_lost_update", {31'd0, bus.pred_taken_o}, 32'd0);

`ifdef BP_STATS_EN
    chk("stat_br_cleared", stat_br, 32'd0);
    @(negedge clk) ex(1, 1, 3'b000, 32'h100, 32'h140, 0, 32'h0, 1, 0);
    @(negedge clk) ex(1, 1, 3'b000, 32'h100, 32'h140, 1, 32'h140, 1, 0);
    @(negedge clk) ex(1, 1, 3'b001, 32'h120, 32'h300, 0, 32'h0, 1, 0);
    @(negedge clk) idle();
    #1;
    chk("stat_br", stat_br, 32'd3);
    chk("stat_misp", stat_misp, 32'd1);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
